drop_controller: RTL and testbench

Sequential move engine for the Connect-Four core. Accepts a column-drop request, scans the column bottom-up for the landing cell, and writes the current player's piece into the board register. It then drives the landed position and the board into the downstream direction checker and qualifies the 13 returned line flags against board bounds. Finally it reports win/draw/reject and alternates players. It owns the authoritative board state.

---
 rtl/drop_controller.sv | 223 ++++++++++++++++++++++
 tb/tb_drop_controller.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/drop_controller.sv
// drop_controller: Connect-Four move engine; scans a column bottom-up, places the piece, qualifies checker flags, reports.
// Latency: done_valid r+4 cycles after accept for landing row r; ROWS+1 for a full column; 1 for an illegal column.
// Backpressure: move_ready is high only in IDLE; requests while busy or after game over are not taken.
// Optional: define DROP_CONTROLLER_DRAW_EN to add the move counter and draw (status 11) detection.
module drop_controller #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int ROW_BITS = 3,
  parameter int COL_BITS = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   new_game,
  input  logic                   move_valid,
  input  logic [COL_BITS-1:0]    move_col,
  output logic                   move_ready,
  output logic                   done_valid,
  output logic [1:0]             done_status,
  output logic                   game_over,
  output logic [1:0]             winner,
  output logic [ROWS*COLS*2-1:0] board_vec,
  output logic [ROW_BITS-1:0]    current_row,
  output logic [COL_BITS-1:0]    current_col,
  output logic [1:0]             current_player,
  input  logic [12:0]            result_flags
);

  localparam int BV_W  = ROWS * COLS * 2;
  localparam int IDX_W = $clog2(BV_W);
`ifdef DROP_CONTROLLER_DRAW_EN
  localparam int CNT_W = ROW_BITS + COL_BITS + 1;
`endif

  typedef enum logic [2:0] {IDLE, SCAN, WRITE, CHECK, REPORT, OVER} state_t;

  state_t              state_q, state_d;
  logic [ROW_BITS-1:0] scan_row_q, scan_row_d;
  logic [BV_W-1:0]     board_q, board_d;
  logic [ROW_BITS-1:0] current_row_q, current_row_d;
  logic [COL_BITS-1:0] current_col_q, current_col_d;
  logic [1:0]          current_player_q, current_player_d;
  logic                move_ready_q, move_ready_d;
  logic                done_valid_q, done_valid_d;
  logic [1:0]          done_status_q, done_status_d;
  logic                game_over_q, game_over_d;
  logic [1:0]          winner_q, winner_d;
`ifdef DROP_CONTROLLER_DRAW_EN
  logic [CNT_W-1:0]    move_count_q, move_count_d;
`endif

  // Cell addressing: the scan pointer reads, the landed position writes.
  logic [IDX_W-1:0] scan_idx, wr_idx;
  logic [1:0]       scan_cell;
  assign scan_idx  = IDX_W'((int'(scan_row_q) * COLS + int'(current_col_q)) * 2);
  assign wr_idx    = IDX_W'((int'(current_row_q) * COLS + int'(current_col_q)) * 2);
  assign scan_cell = board_q[scan_idx +: 2];

  // The checker's index arithmetic wraps, so a flag only counts if its whole
  // 4-cell window lies on the board around the landed position.
  int          row_i, col_i;
  logic [12:0] in_bounds;
  logic        win_hit;
  assign row_i        = int'(current_row_q);
  assign col_i        = int'(current_col_q);
  assign in_bounds[0] = (row_i >= 3);
  for (genvar k = 1; k <= 4; k++) begin : g_mask
    localparam int LO = 4 - k;
    localparam int HI = k - 1;
    assign in_bounds[k]     = (col_i - LO >= 0) && (col_i + HI < COLS);
    assign in_bounds[4 + k] = (row_i - LO >= 0) && (col_i - LO >= 0) &&
                              (row_i + HI < ROWS) && (col_i + HI < COLS);
    assign in_bounds[8 + k] = (row_i + LO < ROWS) && (row_i - HI >= 0) &&
                              (col_i - LO >= 0) && (col_i + HI < COLS);
  end
  assign win_hit = |(result_flags & in_bounds);

  // Next-state logic for the move FSM; new_game overrides everything last.
  always_comb begin
    state_d          = state_q;
    scan_row_d       = scan_row_q;
    board_d          = board_q;
    current_row_d    = current_row_q;
    current_col_d    = current_col_q;
    current_player_d = current_player_q;
    move_ready_d     = move_ready_q;
    done_valid_d     = 1'b0;
    done_status_d    = done_status_q;
    game_over_d      = game_over_q;
    winner_d         = winner_q;
`ifdef DROP_CONTROLLER_DRAW_EN
    move_count_d     = move_count_q;
`endif
    case (state_q)
      IDLE: begin
        if (move_valid && !game_over_q) begin
          current_col_d = move_col;
          move_ready_d  = 1'b0;
          if (int'(move_col) >= COLS) begin
            state_d       = REPORT;
            done_valid_d  = 1'b1;
            done_status_d = 2'b10;
          end else begin
            state_d    = SCAN;
            scan_row_d = '0;
          end
        end
      end
      SCAN: begin
        if (scan_cell == 2'b00) begin
          current_row_d = scan_row_q;
          state_d       = WRITE;
        end else if (int'(scan_row_q) == ROWS - 1) begin
          state_d       = REPORT;
          done_valid_d  = 1'b1;
          done_status_d = 2'b10;
        end else begin
          scan_row_d = scan_row_q + ROW_BITS'(1);
        end
      end
      WRITE: begin
        board_d[wr_idx +: 2] = current_player_q;
`ifdef DROP_CONTROLLER_DRAW_EN
        move_count_d = move_count_q + CNT_W'(1);
`endif
        state_d = CHECK;
      end
      CHECK: begin
        done_valid_d = 1'b1;
        state_d      = REPORT;
        if (win_hit) begin
          done_status_d = 2'b01;
          winner_d      = current_player_q;
          game_over_d   = 1'b1;
        end
`ifdef DROP_CONTROLLER_DRAW_EN
        else if (move_count_q == CNT_W'(ROWS * COLS)) begin
          done_status_d = 2'b11;
          game_over_d   = 1'b1;
        end
`endif
        else begin
          done_status_d = 2'b00;
        end
      end
      REPORT: begin
        if (game_over_q) begin
          state_d = OVER;
        end else begin
          if (done_status_q == 2'b00) begin
            current_player_d = (current_player_q == 2'b01) ? 2'b10 : 2'b01;
          end
          state_d      = IDLE;
          move_ready_d = 1'b1;
        end
      end
      OVER: begin
        move_ready_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (new_game) begin
      state_d          = IDLE;
      board_d          = '0;
      game_over_d      = 1'b0;
      winner_d         = 2'b00;
      done_status_d    = 2'b00;
      done_valid_d     = 1'b0;
      current_player_d = 2'b01;
      move_ready_d     = 1'b1;
`ifdef DROP_CONTROLLER_DRAW_EN
      move_count_d     = '0;
`endif
    end
  end

  // State and registered outputs, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      scan_row_q       <= '0;
      board_q          <= '0;
      current_row_q    <= '0;
      current_col_q    <= '0;
      current_player_q <= 2'b01;
      move_ready_q     <= 1'b1;
      done_valid_q     <= 1'b0;
      done_status_q    <= 2'b00;
      game_over_q      <= 1'b0;
      winner_q         <= 2'b00;
`ifdef DROP_CONTROLLER_DRAW_EN
      move_count_q     <= '0;
`endif
    end else begin
      state_q          <= state_d;
      scan_row_q       <= scan_row_d;
      board_q          <= board_d;
      current_row_q    <= current_row_d;
      current_col_q    <= current_col_d;
      current_player_q <= current_player_d;
      move_ready_q     <= move_ready_d;
      done_valid_q     <= done_valid_d;
      done_status_q    <= done_status_d;
      game_over_q      <= game_over_d;
      winner_q         <= winner_d;
`ifdef DROP_CONTROLLER_DRAW_EN
      move_count_q     <= move_count_d;
`endif
    end
  end

  assign move_ready     = move_ready_q;
  assign done_valid     = done_valid_q;
  assign done_status    = done_status_q;
  assign game_over      = game_over_q;
  assign winner         = winner_q;
  assign board_vec      = board_q;
  assign current_row    = current_row_q;
  assign current_col    = current_col_q;
  assign current_player = current_player_q;

endmodule

// File: tb/tb_drop_controller.sv
// tb_drop_controller: directed table of moves with hand-computed status, latency, row and board,
// plus hand-written sequences for game-over lockout, new_game abort, full board and async reset.
module tb_drop_controller;

  localparam int ROWS = 8;
  localparam int COLS = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         new_game = 1'b0;
  logic         move_valid = 1'b0;
  logic [2:0]   move_col = 3'd0;
  logic         move_ready;
  logic         done_valid;
  logic [1:0]   done_status;
  logic         game_over;
  logic [1:0]   winner;
  logic [127:0] board_vec;
  logic [2:0]   current_row;
  logic [2:0]   current_col;
  logic [1:0]   current_player;
  logic [12:0]  flags_in = 13'h0;

  int checks = 0;
  int failures = 0;

  drop_controller dut (
    .clk            (clk),
    .rst            (rst),
    .new_game       (new_game),
    .move_valid     (move_valid),
    .move_col       (move_col),
    .move_ready     (move_ready),
    .done_valid     (done_valid),
    .done_status    (done_status),
    .game_over      (game_over),
    .winner         (winner),
    .board_vec      (board_vec),
    .current_row    (current_row),
    .current_col    (current_col),
    .current_player (current_player),
    .result_flags   (flags_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ng;
    int          col;
    logic [12:0] fl;
    int          st;
    int          lat;
    int          row;
    logic [1:0]  nxt;
    logic        rdy;
    logic        go;
    logic [1:0]  win;
  } vec_t;

  localparam int NV = 21;
  vec_t vt [NV];

  function automatic vec_t mk(input bit ng, input int col, input logic [12:0] fl, input int st,
                              input int lat, input int row, input logic [1:0] nxt,
                              input logic rdy, input logic go, input logic [1:0] win);
    vec_t v;
    v.ng = ng; v.col = col; v.fl = fl; v.st = st; v.lat = lat;
    v.row = row; v.nxt = nxt; v.rdy = rdy; v.go = go; v.win = win;
    return v;
  endfunction

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_new_game();
    new_game = 1'b1;
    @(posedge clk); #1;
    new_game = 1'b0;
  endtask

  // Issue a drop in the current (IDLE) cycle, wait for done_valid, then step one cycle past it.
  task automatic apply_move(input int col, input logic [12:0] fl, output int st, output int lat, output int row);
    st = -1; lat = -1; row = -1;
    move_col = 3'(col);
    flags_in = fl;
    move_valid = 1'b1;
    @(posedge clk); #1;
    move_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (done_valid) begin
        st = int'(done_status);
        lat = n;
        row = int'(current_row);
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (lat < 0) begin
      failures++;
      $display("FAIL move_timeout: col=%0d no done_valid within 40 cycles", col);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [127:0] exp_board;
    logic [1:0]   exp_cur;
    int st, lat, row, pulses;

    // Game A: vertical win in col 2, with masked flags on the way.
    vt[0]  = mk(0, 3, 13'h000, 0, 4, 0, 2'b10, 1, 0, 2'b00);
    vt[1]  = mk(0, 4, 13'h020, 0, 4, 0, 2'b01, 1, 0, 2'b00);
    vt[2]  = mk(0, 2, 13'h002, 0, 4, 0, 2'b10, 1, 0, 2'b00);
    vt[3]  = mk(0, 4, 13'h000, 0, 5, 1, 2'b01, 1, 0, 2'b00);
    vt[4]  = mk(0, 2, 13'h000, 0, 5, 1, 2'b10, 1, 0, 2'b00);
    vt[5]  = mk(0, 4, 13'h1000, 0, 6, 2, 2'b01, 1, 0, 2'b00);
    vt[6]  = mk(0, 2, 13'h000, 0, 6, 2, 2'b10, 1, 0, 2'b00);
    vt[7]  = mk(0, 5, 13'h000, 0, 4, 0, 2'b01, 1, 0, 2'b00);
    vt[8]  = mk(0, 2, 13'h001, 1, 7, 3, 2'b01, 0, 1, 2'b01);
    // Game B: fill col 0, reject the ninth drop, then a horizontal win in col 1.
    for (int k = 0; k < 8; k++)
      vt[9 + k] = mk(k == 0, 0, 13'h000, 0, k + 4, k, (k % 2 == 0) ? 2'b10 : 2'b01, 1, 0, 2'b00);
    vt[17] = mk(0, 0, 13'h000, 2, 9, -1, 2'b01, 1, 0, 2'b00);
    vt[18] = mk(0, 1, 13'h001, 0, 4, 0, 2'b10, 1, 0, 2'b00);
    vt[19] = mk(0, 1, 13'h002, 0, 5, 1, 2'b01, 1, 0, 2'b00);
    vt[20] = mk(0, 1, 13'h010, 1, 6, 2, 2'b01, 0, 1, 2'b01);

    // Reset values, checked while rst is held.
    #12;
    chk_i("rst move_ready", int'(move_ready), 1);
    chk_i("rst done_valid", int'(done_valid), 0);
    chk_i("rst done_status", int'(done_status), 0);
    chk_i("rst game_over", int'(game_over), 0);
    chk_i("rst winner", int'(winner), 0);
    chk_b("rst board", board_vec, 128'h0);
    chk_i("rst current_row", int'(current_row), 0);
    chk_i("rst current_col", int'(current_col), 0);
    chk_i("rst current_player", int'(current_player), 1);
    @(posedge clk); #1;
    rst = 1'b0;

    exp_board = '0;
    exp_cur = 2'b01;
    for (int i = 0; i < NV; i++) begin
      if (vt[i].ng) begin
        do_new_game();
        exp_board = '0;
        exp_cur = 2'b01;
      end
      apply_move(vt[i].col, vt[i].fl, st, lat, row);
      if (vt[i].row >= 0) exp_board[(vt[i].row * COLS + vt[i].col) * 2 +: 2] = exp_cur;
      chk_i($sformatf("v%0d status", i), st, vt[i].st);
      chk_i($sformatf("v%0d latency", i), lat, vt[i].lat);
      if (vt[i].row >= 0) chk_i($sformatf("v%0d row", i), row, vt[i].row);
      chk_b($sformatf("v%0d board", i), board_vec, exp_board);
      chk_i($sformatf("v%0d player", i), int'(current_player), int'(vt[i].nxt));
      chk_i($sformatf("v%0d move_ready", i), int'(move_ready), int'(vt[i].rdy));
      chk_i($sformatf("v%0d game_over", i), int'(game_over), int'(vt[i].go));
      chk_i($sformatf("v%0d winner", i), int'(winner), int'(vt[i].win));
      exp_cur = vt[i].nxt;
    end

    // OVER ignores drop requests.
    pulses = 0;
    move_col = 3'd3;
    move_valid = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (done_valid) pulses++;
    end
    move_valid = 1'b0;
    chk_i("over pulses", pulses, 0);
    chk_i("over move_ready", int'(move_ready), 0);
    chk_b("over board", board_vec, exp_board);

    // new_game clears the finished game.
    do_new_game();
    chk_b("ng board", board_vec, 128'h0);
    chk_i("ng player", int'(current_player), 1);
    chk_i("ng move_ready", int'(move_ready), 1);
    chk_i("ng game_over", int'(game_over), 0);
    chk_i("ng winner", int'(winner), 0);
    chk_i("ng done_status", int'(done_status), 0);

    // new_game during SCAN aborts the move without a done pulse.
    apply_move(6, 13'h000, st, lat, row);
    chk_i("pre-abort status", st, 0);
    move_col = 3'd6;
    move_valid = 1'b1;
    @(posedge clk); #1;
    move_valid = 1'b0;
    new_game = 1'b1;
    @(posedge clk); #1;
    new_game = 1'b0;
    chk_b("abort board", board_vec, 128'h0);
    chk_i("abort player", int'(current_player), 1);
    chk_i("abort move_ready", int'(move_ready), 1);
    pulses = int'(done_valid);
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (done_valid) pulses++;
    end
    chk_i("abort pulses", pulses, 0);

    // Fill all 64 cells column by column with no line flags.
    for (int i = 0; i < ROWS * COLS; i++) begin
      int exp_st;
`ifdef DROP_CONTROLLER_DRAW_EN
      exp_st = (i == ROWS * COLS - 1) ? 3 : 0;
`else
      exp_st = 0;
`endif
      apply_move(i / ROWS, 13'h000, st, lat, row);
      chk_i($sformatf("fill%0d status", i), st, exp_st);
      chk_i($sformatf("fill%0d row", i), row, i % ROWS);
    end
`ifdef DROP_CONTROLLER_DRAW_EN
    chk_i("draw game_over", int'(game_over), 1);
    chk_i("draw move_ready", int'(move_ready), 0);
    chk_i("draw winner", int'(winner), 0);
`else
    apply_move(0, 13'h000, st, lat, row);
    chk_i("full-board status", st, 2);
    chk_i("full-board latency", lat, ROWS + 1);
    chk_i("full-board game_over", int'(game_over), 0);
`endif

    // Asynchronous reset in the middle of a scan.
    do_new_game();
    apply_move(5, 13'h000, st, lat, row);
    chk_i("pre-rst player", int'(current_player), 2);
    move_col = 3'd5;
    move_valid = 1'b1;
    @(posedge clk); #1;
    move_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    chk_b("arst board", board_vec, 128'h0);
    chk_i("arst player", int'(current_player), 1);
    chk_i("arst move_ready", int'(move_ready), 1);
    chk_i("arst done_valid", int'(done_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
